// File: rtl/uart_tx_stream_if.sv
// rtl/uart_tx_stream_if.sv - word stream handshake into the UART transmitter
interface uart_tx_stream_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx_stream.sv
// rtl/uart_tx_stream.sv - buffered UART transmitter with configurable frame format
module uart_tx_stream #(
  parameter int CLK_DIV    = 833,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  uart_tx_stream_if.slave               s_if,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [LW-1:0]        level_q;
  logic [LW-1:0]        level_d;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  state_t               state_q;
  state_t               state_d;
  logic [CW-1:0]        baud_q;
  logic [CW-1:0]        baud_d;
  logic [BW-1:0]        bit_q;
  logic [BW-1:0]        bit_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic                 par_q;
  logic                 par_d;
  logic                 tx_q;
  logic                 tx_d;
  logic                 busy_q;
  logic                 baud_last;

  // Parity of the whole word, taken once when the word is loaded
  function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
    return (PARITY == 2) ? ^w : ~^w;
  endfunction

  assign s_if.ready = (level_q != LW'(FIFO_DEPTH));
  assign push       = s_if.valid && s_if.ready;
  assign head       = mem_q[rd_ptr_q];
  assign level_d    = level_q + LW'(push) - LW'(pop);
  assign baud_last  = (baud_q == CW'(CLK_DIV - 1));

  assign tx_o    = tx_q;
  assign busy_o  = busy_q;
  assign level_o = level_q;

  // FIFO storage: written on every accepted word, never reset
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_if.data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_d;
    end
  end

  // Frame state register; tx and busy are registered so the pin never glitches
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // Next-state, FIFO pop and line level for the following cycle
  always_comb begin
    state_d = state_q;
    baud_d  = baud_last ? '0 : baud_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    tx_d    = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (level_q != '0) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = parity_of(head);
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PAR: begin
        if (baud_last) begin
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          if (bit_q == BW'(STOP_BITS - 1)) begin
            bit_d = '0;
            // Back-to-back frames: the next word starts with no idle gap
            if (level_q != '0) begin
              pop     = 1'b1;
              shift_d = head;
              par_d   = parity_of(head);
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      S_PAR:   tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// tb/tb_uart_tx_stream.sv - randomized scoreboard bench for three transmitter configurations
module tb_uart_tx_stream;

  typedef logic [8:0] word_t;

  logic clk;
  logic rst;
  logic tx_a, tx_b, tx_c;
  logic busy_a, busy_b, busy_c;
  logic [2:0] lvl_a;
  logic [2:0] lvl_b;
  logic [3:0] lvl_c;

  int n_checks = 0;
  int n_errors = 0;

  // Frame format of each instance: a = 8N1, b = 9O2, c = 7E1
  int cdiv  [3] = '{4, 3, 5};
  int nbits [3] = '{8, 9, 7};
  int npar  [3] = '{0, 1, 2};
  int nstop [3] = '{1, 2, 1};
  int depth [3] = '{4, 4, 8};

  word_t sbq [3][$];
  int    last_run [3] = '{0, 0, 0};

  uart_tx_stream_if #(.DATA_BITS(8)) if_a ();
  uart_tx_stream_if #(.DATA_BITS(9)) if_b ();
  uart_tx_stream_if #(.DATA_BITS(7)) if_c ();

  uart_tx_stream #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .s_if(if_a), .tx_o(tx_a), .busy_o(busy_a), .level_o(lvl_a));
  uart_tx_stream #(.CLK_DIV(3), .DATA_BITS(9), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .s_if(if_b), .tx_o(tx_b), .busy_o(busy_b), .level_o(lvl_b));
  uart_tx_stream #(.CLK_DIV(5), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(8)) dut_c (
    .clk_i(clk), .rst_i(rst), .s_if(if_c), .tx_o(tx_c), .busy_o(busy_c), .level_o(lvl_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  function automatic logic get_tx(input int d);
    case (d)
      0: return tx_a;
      1: return tx_b;
      default: return tx_c;
    endcase
  endfunction

  function automatic logic get_busy(input int d);
    case (d)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic int get_level(input int d);
    case (d)
      0: return int'(lvl_a);
      1: return int'(lvl_b);
      default: return int'(lvl_c);
    endcase
  endfunction

  function automatic logic get_ready(input int d);
    case (d)
      0: return if_a.ready;
      1: return if_b.ready;
      default: return if_c.ready;
    endcase
  endfunction

  task automatic set_in(input int d, input logic v, input word_t w);
    case (d)
      0: begin if_a.valid = v; if_a.data = w[7:0]; end
      1: begin if_b.valid = v; if_b.data = w; end
      default: begin if_c.valid = v; if_c.data = w[6:0]; end
    endcase
  endtask

  function automatic int flen(input int d);
    return 1 + nbits[d] + ((npar[d] != 0) ? 1 : 0) + nstop[d];
  endfunction

  // Expected line bits of one frame, bit 0 first on the wire; unused upper bits are 1
  function automatic logic [15:0] exp_frame(input int d, input word_t w);
    logic [15:0] f;
    int pos;
    int ones;
    f = '1;
    f[0] = 1'b0;
    pos = 1;
    ones = 0;
    for (int i = 0; i < nbits[d]; i++) begin
      f[pos] = w[i];
      ones += int'(w[i]);
      pos++;
    end
    if (npar[d] == 2) f[pos] = ((ones % 2) == 1);
    if (npar[d] == 1) f[pos] = ((ones % 2) == 0);
    return f;
  endfunction

  // Line monitor: decodes each frame, checks bit timing, busy and occupancy every cycle
  task automatic monitor(input int d);
    bit cap;
    int n;
    int bad;
    int run;
    int k;
    logic [15:0] seen;
    word_t w;
    cap = 0; n = 0; bad = 0; run = 0; seen = '1; w = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cap = 0;
        run = 0;
      end else begin
        if (get_busy(d)) run++;
        else if (run != 0) begin
          last_run[d] = run;
          run = 0;
        end
        if (!cap && get_tx(d) == 1'b0) begin
          if (sbq[d].size() == 0) begin
            check_eq($sformatf("spurious_start%0d", d), 1, 0);
          end else begin
            w = sbq[d].pop_front();
            cap = 1; n = 0; bad = 0; seen = '1;
          end
        end
        if (cap) begin
          k = n / cdiv[d];
          if ((n % cdiv[d]) == 0) seen[k] = get_tx(d);
          else if (seen[k] != get_tx(d)) bad++;
          if (!get_busy(d)) bad++;
          n++;
          if (n == flen(d) * cdiv[d]) begin
            check_eq($sformatf("frame%0d_w%0h", d, w), int'(seen), int'(exp_frame(d, w)));
            check_eq($sformatf("bit_hold%0d", d), bad, 0);
            cap = 0;
          end
        end
        check_eq($sformatf("level%0d", d), get_level(d), sbq[d].size());
      end
    end
  endtask

  // Offer one word; caller and return are both 1 time unit after a rising edge
  task automatic push(input int d, input word_t w);
    logic r;
    int tries;
    tries = 0;
    forever begin
      set_in(d, 1'b1, w);
      r = get_ready(d);
      @(posedge clk);
      #1;
      if (r) begin
        sbq[d].push_back(w);
        break;
      end
      tries++;
      if (tries > 2000) begin
        check_eq($sformatf("push_timeout%0d", d), 0, 1);
        break;
      end
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int d);
    int t;
    t = 0;
    while (!(get_busy(d) == 1'b0 && get_level(d) == 0)) begin
      cycle(1);
      t++;
      if (t > 3000) begin
        check_eq($sformatf("idle_timeout%0d", d), 0, 1);
        break;
      end
    end
    cycle(1);
  endtask

  task automatic wait_tx_low(input int d);
    int t;
    t = 0;
    while (get_tx(d) != 1'b0) begin
      cycle(1);
      t++;
      if (t > 200) begin
        check_eq($sformatf("start_timeout%0d", d), 0, 1);
        break;
      end
    end
  endtask

  task automatic rand_stream(input int d, input int count);
    word_t mask;
    word_t w;
    mask = word_t'((1 << nbits[d]) - 1);
    for (int i = 0; i < count; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        set_in(d, 1'b0, '0);
        cycle($urandom_range(1, 60));
      end
      w = word_t'($urandom) & mask;
      push(d, w);
    end
    set_in(d, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) set_in(d, 1'b0, '0);
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none
    cycle(3);
    rst = 1'b0;

    // Reset state of every instance
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("rst_tx%0d", d), int'(get_tx(d)), 1);
      check_eq($sformatf("rst_busy%0d", d), int'(get_busy(d)), 0);
      check_eq($sformatf("rst_level%0d", d), get_level(d), 0);
      check_eq($sformatf("rst_ready%0d", d), int'(get_ready(d)), 1);
    end

    // Push into an idle, empty transmitter: level next cycle, start bit the cycle after
    push(0, 9'h021);
    set_in(0, 1'b0, '0);
    check_eq("lat_level", get_level(0), 1);
    check_eq("lat_idle_tx", int'(get_tx(0)), 1);
    cycle(1);
    check_eq("lat_start_tx", int'(get_tx(0)), 0);
    check_eq("lat_busy", int'(get_busy(0)), 1);
    wait_idle(0);
    check_eq("run_8n1", last_run[0], 40);

    // Parity and stop-bit formats, 9-bit data with bit 8 set
    push(1, 9'h007);
    push(1, 9'h1a5);
    set_in(1, 1'b0, '0);
    push(2, 9'h007);
    set_in(2, 1'b0, '0);
    wait_idle(1);
    wait_idle(2);
    check_eq("run_9o2", last_run[1], 2 * 39);
    check_eq("run_7e1", last_run[2], 50);

    // Back-to-back burst into depth 4: fills, stalls, then frames run gap-free
    for (int i = 0; i < 5; i++) push(0, word_t'(8'h30 + i));
    check_eq("full_ready", int'(get_ready(0)), 0);
    check_eq("full_level", get_level(0), 4);
    push(0, 9'h0c5);
    set_in(0, 1'b0, '0);
    wait_idle(0);
    check_eq("burst_run", last_run[0], 6 * 40);
    check_eq("burst_busy", int'(get_busy(0)), 0);

    // Push landing on the same edge as the pop, with two words queued
    push(0, 9'h011);
    push(0, 9'h022);
    push(0, 9'h033);
    set_in(0, 1'b0, '0);
    wait_tx_low(0);
    cycle(39);
    push(0, 9'h044);
    set_in(0, 1'b0, '0);
    check_eq("pushpop_level", get_level(0), 2);
    wait_idle(0);

    // Reset in the middle of data bit 3 aborts the frame and empties the FIFO
    push(0, 9'h0f0);
    push(0, 9'h055);
    push(0, 9'h0aa);
    set_in(0, 1'b0, '0);
    wait_tx_low(0);
    cycle(17);
    rst = 1'b1;
    for (int d = 0; d < 3; d++) sbq[d].delete();
    cycle(1);
    rst = 1'b0;
    check_eq("midrst_tx", int'(get_tx(0)), 1);
    check_eq("midrst_level", get_level(0), 0);
    check_eq("midrst_busy", int'(get_busy(0)), 0);
    check_eq("midrst_ready", int'(get_ready(0)), 1);
    cycle(2);
    push(0, 9'h0b6);
    set_in(0, 1'b0, '0);
    wait_idle(0);
    check_eq("postrst_run", last_run[0], 40);

    // Random traffic with bursts and gaps on all three formats concurrently
    fork
      rand_stream(0, 20);
      rand_stream(1, 20);
      rand_stream(2, 20);
    join
    for (int d = 0; d < 3; d++) wait_idle(d);
    for (int d = 0; d < 3; d++) check_eq($sformatf("drained%0d", d), sbq[d].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
